// File: rtl/pattern_detector_if.sv
// Serial pattern-detector bus: stream, pattern-load and counter controls plus detection outputs.
// The stream/control side is the master; pattern_detector is the slave.
interface pattern_detector_if #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 en;
    logic                 si;
    logic                 overlap;
    logic [WIDTH-1:0]     pattern_in;
    logic                 pattern_load;
    logic                 count_clear;
    logic                 detected;
    logic [CNT_WIDTH-1:0] match_count;

    modport master (
        output en, si, overlap, pattern_in, pattern_load, count_clear,
        input  detected, match_count
    );

    modport slave (
        input  en, si, overlap, pattern_in, pattern_load, count_clear,
        output detected, match_count
    );
endinterface

// File: rtl/pattern_detector.sv
// Parametrised serial bit-pattern detector with run-time pattern reload and overlap select.
// Optional saturating match counter built only when PATTERN_DETECTOR_COUNTER_EN is defined.
module pattern_detector #(
    parameter int unsigned         WIDTH     = 3,
    parameter logic [WIDTH-1:0]    PATTERN   = WIDTH'(3'b110),
    parameter int unsigned         CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pattern_detector_if.slave    io_bus
);
    localparam int unsigned        FillW    = $clog2(WIDTH + 1);
    localparam logic [FillW-1:0]   FillFull = FillW'(WIDTH);
    localparam logic [FillW-1:0]   FillLast = FillW'(WIDTH - 1);

    logic [WIDTH-1:0] r_pat;
    logic [WIDTH-1:0] r_hist;
    logic [FillW-1:0] r_fill;
    logic             r_detected;

    logic [WIDTH-1:0] w_nxt;
    logic [FillW-1:0] w_fill_next;
    logic             w_accept;
    logic             w_match;
    logic             w_detected_next;

    // A load in the same cycle swallows the presented bit.
    assign w_accept = io_bus.en & ~io_bus.pattern_load;
    assign w_nxt    = {r_hist[WIDTH-2:0], io_bus.si};
    assign w_match  = w_accept && (r_fill >= FillLast) && (w_nxt == r_pat);

    // fill is the FSM state: FILL_0 .. FILL_(W-1), ARMED == WIDTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fill <= '0;
        end else begin
            r_fill <= w_fill_next;
        end
    end

    always_comb begin
        w_fill_next = r_fill;
        if (io_bus.pattern_load) begin
            w_fill_next = '0;
        end else if (w_accept) begin
            if (w_match && !io_bus.overlap) begin
                w_fill_next = '0;
            end else if (r_fill != FillFull) begin
                w_fill_next = r_fill + 1'b1;
            end
        end
    end

    always_comb begin
        w_detected_next = w_match;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pat      <= PATTERN;
            r_hist     <= '0;
            r_detected <= 1'b0;
        end else begin
            r_detected <= w_detected_next;
            if (io_bus.pattern_load) begin
                r_pat <= io_bus.pattern_in;
            end else if (io_bus.en) begin
                r_hist <= w_nxt;
            end
        end
    end

    assign io_bus.detected = r_detected;

`ifdef PATTERN_DETECTOR_COUNTER_EN
    localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] r_count;

    // Clear wins over a coincident match; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (io_bus.count_clear) begin
            r_count <= '0;
        end else if (w_match && (r_count != CntMax)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign io_bus.match_count = r_count;
`else
    logic w_unused_count_clear;

    assign w_unused_count_clear = io_bus.count_clear;
    assign io_bus.match_count   = '0;
`endif
endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector (WIDTH=3, CNT_WIDTH=2): expected flag/count pushed
// to a scoreboard when each cycle is driven, popped and asserted after the edge.
module tb_pattern_detector;
    localparam int unsigned WIDTH     = 3;
    localparam int unsigned CNT_WIDTH = 2;

    typedef struct {
        logic                 det;
        logic [CNT_WIDTH-1:0] cnt;
        string                tag;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    exp_t sb[$];
    logic [CNT_WIDTH-1:0] m_cnt;

    pattern_detector_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    pattern_detector #(
        .WIDTH     (WIDTH),
        .PATTERN   (3'b110),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic en, input logic si, input logic load,
                        input logic [WIDTH-1:0] pin, input logic clr, input logic rst,
                        input logic exp_det, input string tag);
        exp_t e;
        reset            = rst;
        bus.en           = en;
        bus.si           = si;
        bus.pattern_load = load;
        bus.pattern_in   = pin;
        bus.count_clear  = clr;
`ifdef PATTERN_DETECTOR_COUNTER_EN
        if (rst || clr) begin
            m_cnt = '0;
        end else if (exp_det && (m_cnt != {CNT_WIDTH{1'b1}})) begin
            m_cnt = m_cnt + 1'b1;
        end
`else
        m_cnt = '0;
`endif
        e.det = exp_det;
        e.cnt = m_cnt;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_cmp++;
        assert (bus.detected === e.det) else begin
            n_fail++;
            $error("FAIL %s.detected: observed %0b expected %0b", e.tag, bus.detected, e.det);
        end
        n_cmp++;
        assert (bus.match_count === e.cnt) else begin
            n_fail++;
            $error("FAIL %s.match_count: observed %0d expected %0d", e.tag,
                   bus.match_count, e.cnt);
        end
    endtask

    task automatic bit_in(input logic si, input logic exp_det, input string tag);
        step(1'b1, si, 1'b0, '0, 1'b0, 1'b0, exp_det, tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic load(input logic [WIDTH-1:0] p, input string tag);
        step(1'b1, 1'b0, 1'b1, p, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        m_cnt       = '0;
        bus.overlap = 1'b0;

        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, "reset");

        // Default pattern 110, no overlap.
        bit_in(1'b1, 1'b0, "def_b1");
        bit_in(1'b1, 1'b0, "def_b2");
        bit_in(1'b0, 1'b1, "def_b3");
        idle("def_after");

        // 101 with overlap: pulses after bits 3 and 5.
        bus.overlap = 1'b1;
        load(3'b101, "ld101_ov");
        bit_in(1'b1, 1'b0, "ov_b1");
        bit_in(1'b0, 1'b0, "ov_b2");
        bit_in(1'b1, 1'b1, "ov_b3");
        bit_in(1'b0, 1'b0, "ov_b4");
        bit_in(1'b1, 1'b1, "ov_b5");

        // 101 without overlap: only bit 3.
        bus.overlap = 1'b0;
        load(3'b101, "ld101_nov");
        bit_in(1'b1, 1'b0, "nov_b1");
        bit_in(1'b0, 1'b0, "nov_b2");
        bit_in(1'b1, 1'b1, "nov_b3");
        bit_in(1'b0, 1'b0, "nov_b4");
        bit_in(1'b1, 1'b0, "nov_b5");

        // 110 with en gaps of three cycles.
        load(3'b110, "ld110_gap");
        bit_in(1'b1, 1'b0, "gap_b1");
        for (int i = 0; i < 3; i++) idle("gap_idle1");
        bit_in(1'b1, 1'b0, "gap_b2");
        for (int i = 0; i < 3; i++) idle("gap_idle2");
        bit_in(1'b0, 1'b1, "gap_b3");
        for (int i = 0; i < 3; i++) idle("gap_idle3");

        // Load discards the coincident bit; stale history never matches.
        load(3'b110, "ld110_stale");
        bit_in(1'b1, 1'b0, "stale_b1");
        bit_in(1'b1, 1'b0, "stale_b2");
        load(3'b011, "ld011_discard");
        bit_in(1'b0, 1'b0, "stale_b3");
        bit_in(1'b1, 1'b0, "stale_b4");
        bit_in(1'b1, 1'b1, "stale_b5");

        // Mid-stream reset, overriding a coincident load.
        load(3'b110, "ld110_rst");
        bit_in(1'b1, 1'b0, "rst_b1");
        bit_in(1'b1, 1'b0, "rst_b2");
        step(1'b1, 1'b0, 1'b1, 3'b011, 1'b0, 1'b1, 1'b0, "rst_over_load");
        bit_in(1'b0, 1'b0, "rst_b3");
        bit_in(1'b1, 1'b0, "rst_b4");
        bit_in(1'b1, 1'b0, "rst_b5");
        bit_in(1'b0, 1'b1, "rst_b6");

        // Back-to-back pulses with overlap on pattern 111.
        bus.overlap = 1'b1;
        load(3'b111, "ld111");
        bit_in(1'b1, 1'b0, "b2b_b1");
        bit_in(1'b1, 1'b0, "b2b_b2");
        bit_in(1'b1, 1'b1, "b2b_b3");
        bit_in(1'b1, 1'b1, "b2b_b4");
        bit_in(1'b1, 1'b1, "b2b_b5");
        bit_in(1'b1, 1'b1, "b2b_b6");

        // Clear coincident with a match leaves the count at zero.
        step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1, "clr_with_match");
        bit_in(1'b1, 1'b1, "after_clr");
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, "clr_idle");
        idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
